io_spi_target: RTL and testbench
================================

Name: io_spi_target

Overview:
- SPI target (slave) peripheral on the dma_io register bus. It is the responder-side counterpart of the SPI-lite master, so the CPU can act as an SPI device to an external host, or loop back to the on-chip master for self-test.
- Supports mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Buffers transmit and receive bytes in small FIFOs.
- Takes part in the dma_io read-data daisy chain and raises a one-shot receive interrupt.

Parameters:
- ADR_BASE, 14'h3F20, word address of register 0 (byte address 0xFC80); registers occupy ADR_BASE+0..2.
- FIFO_DEPTH_LOG2, 2, log2 of the TX and RX FIFO depth (4 entries each).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- dma_io_we  input  1  io bus write strobe
- dma_io_wadr  input  14 [15:2]  io write word address
- dma_io_wdata  input  32  io write data
- dma_io_radr  input  14 [15:2]  io read word address
- dma_io_radr_en  input  1  io read strobe
- dma_io_rdata_in  input  32  upstream chained read data
- dma_io_rdata  output  32  chained read data out
- spi_sck_in  input  1  external SCK (asynchronous)
- spi_csn_in  input  1  external chip select, active low (asynchronous)
- spi_mosi_in  input  1  external MOSI (asynchronous)
- spi_miso_out  output  1  MISO data
- spi_miso_oe  output  1  MISO output enable
- spi_rx_1shot  output  1  one-cycle pulse per received byte, when enabled

Behaviour:
- Reset: all outputs 0 except dma_io_rdata, which equals dma_io_rdata_in. FIFOs empty, CTRL=0, sticky flags 0, bit counter 0.
- Synchronisers: SCK, CSN and MOSI each pass through 2 flops; an edge detect uses a third flop on SCK and CSN. SCK high and low times must each be at least 4 clk cycles.
- Registers:
  - ADR_BASE+0 DATA
    - Write: pushes wdata[7:0] into TX FIFO. If TX FIFO is full, the write is dropped and tx_ovf is set.
    - Read: returns {23'd0, rx_valid, rx_head[7:0]}. If RX is non-empty, the same cycle pops it.
  - ADR_BASE+1 STATUS
    - Read fields: [17:16] rx_count low bits, [15:8] reserved 0, [7:5] tx_count, [4:2] rx_count, [3] rx_ovf, [2] tx_ovf, [1] tx_underrun, [0] cs_active. Fields overlap; the final encoding is [12:10] rx_count, [9:7] tx_count, [3:0] as listed, other bits 0.
    - Write: W1C on bits [3:1].
  - ADR_BASE+2 CTRL, R/W: [0] enable, [1] irq_en, [15:8] default_byte. A CTRL write with enable=0 also flushes both FIFOs.
- Read mux is combinational. If dma_io_radr_en and dma_io_radr hits ADR_BASE..+2, drive the register value; otherwise pass dma_io_rdata_in through.
- FSM: IDLE -> LOAD -> SHIFT -> IDLE.
  - IDLE: on synced CSN falling edge while enable=1, go to LOAD.
  - LOAD, one cycle: shift_tx = TX head (pop), or default_byte if TX is empty (set tx_underrun). bitcnt=0. miso_oe=1. spi_miso_out=shift_tx[7]. Go to SHIFT.
  - SHIFT:
    - Synced SCK rising: shift_rx = {shift_rx[6:0], mosi_sync}; bitcnt++.
    - When bitcnt wraps 7->0: push shift_rx to RX FIFO. If RX is full, drop the byte and set rx_ovf. Pulse spi_rx_1shot if irq_en. Raise reload flag.
    - Synced SCK falling: if reload is set, load the next TX byte (same rules as LOAD) and drive bit 7; otherwise shift_tx <<= 1 and drive the new bit 7.
    - Synced CSN rising edge, from any state: abort. Partial byte is discarded, miso_oe=0, miso_out=0, go to IDLE.
- enable=0 while in SHIFT: immediate return to IDLE, outputs 0.
- Simultaneous CPU DATA read pop and FIFO push: count unchanged, both operations take effect. Same rule for a TX write and a pop.
- FIFO pointers wrap modulo depth. Counts span 0..DEPTH.

Test Plan:
1. Reset, then read ADR_BASE+1 -> 0; read unrelated address with rdata_in=32'hdeadbeef -> 32'hdeadbeef.
2. enable=1, write DATA 8'hA5; host sends 8'h3C with SCK = clk/10 -> MISO bits 1,0,1,0,0,1,0,1; DATA read = 32'h13C; rx_count 1->0 after read.
3. irq_en=1, TX empty, default_byte=8'hFF; host clocks 2 bytes -> MISO all 1s; tx_underrun=1; spi_rx_1shot pulses exactly twice; W1C 32'h2 clears the flag.
4. Host sends 5 bytes without CPU reads -> rx_count=4, rx_ovf=1, first 4 bytes read back in order.
5. CSN deasserted after 3 SCK edges -> no RX push, miso_oe=0 within 4 cycles; the next full frame is received correctly.
6. Write DATA 5 times with no transfer -> tx_ovf=1, tx_count=4; CTRL write with enable=0 flushes -> tx_count=0.

Source files
------------

// File: rtl/io_spi_target.sv
// ---------------------------------------------------------------------------
// io_spi_target
//    SPI target (slave) on the dma_io register bus. An external host, or the
//    on-chip SPI-lite master in loop-back, clocks 8-bit mode-0 frames, MSB
//    first. Transmit and receive bytes are buffered in small FIFOs. The CPU
//    reaches them through three word registers, and a one-cycle pulse marks
//    each received byte.
//
// Ports
//    clk, rst_n          system clock, asynchronous active-low reset
//    dma_io_we/wadr/wdata  io bus write strobe, word address, data
//    dma_io_radr/radr_en   io bus read word address and strobe
//    dma_io_rdata_in       upstream read data in the daisy chain
//    dma_io_rdata          chained read data out (combinational)
//    spi_sck_in/csn_in/mosi_in  asynchronous SPI inputs from the host
//    spi_miso_out/miso_oe  MISO data and output enable
//    spi_rx_1shot          one-cycle pulse per received byte when irq_en=1
//
// Registers (word offsets from ADR_BASE)
//    +0 DATA    wr: push TX byte     rd: {rx_valid, rx_head}, pops RX
//    +1 STATUS  [12:10] rx_count [9:7] tx_count [3] rx_ovf [2] tx_ovf
//               [1] tx_underrun [0] cs_active; write-1-to-clear on [3:1]
//    +2 CTRL    [0] enable [1] irq_en [15:8] default_byte;
//               a write with enable=0 flushes both FIFOs
// ---------------------------------------------------------------------------
module io_spi_target #(
   parameter logic [13:0] ADR_BASE        = 14'h3F20,
   parameter int          FIFO_DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic        dma_io_radr_en,
   input  logic [31:0] dma_io_rdata_in,
   output logic [31:0] dma_io_rdata,
   input  logic        spi_sck_in,
   input  logic        spi_csn_in,
   input  logic        spi_mosi_in,
   output logic        spi_miso_out,
   output logic        spi_miso_oe,
   output logic        spi_rx_1shot
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int PW    = FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;

   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   localparam logic [13:0] ADR_DATA = ADR_BASE;
   localparam logic [13:0] ADR_STAT = ADR_BASE + 14'd1;
   localparam logic [13:0] ADR_CTRL = ADR_BASE + 14'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers. The third SCK/CSN flop holds the previous
   // synchronised value for edge detection. CSN idles high, so its flops
   // reset to 1 so that leaving reset does not look like an edge.
   // ------------------------------------------------------------------
   logic [2:0] sck_q;
   logic [2:0] csn_q;
   logic [1:0] mosi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_q  <= 3'b000;
         csn_q  <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], spi_sck_in};
         csn_q  <= {csn_q[1:0], spi_csn_in};
         mosi_q <= {mosi_q[0], spi_mosi_in};
      end
   end

   logic sck_rise, sck_fall, csn_fall, csn_rise, mosi_s, cs_active;
   assign sck_rise  =  sck_q[1] & ~sck_q[2];
   assign sck_fall  = ~sck_q[1] &  sck_q[2];
   assign csn_fall  = ~csn_q[1] &  csn_q[2];
   assign csn_rise  =  csn_q[1] & ~csn_q[2];
   assign mosi_s    =  mosi_q[1];
   assign cs_active = ~csn_q[1];

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic wr_data, wr_stat, wr_ctrl, rd_data;
   assign wr_data = dma_io_we & (dma_io_wadr == ADR_DATA);
   assign wr_stat = dma_io_we & (dma_io_wadr == ADR_STAT);
   assign wr_ctrl = dma_io_we & (dma_io_wadr == ADR_CTRL);
   assign rd_data = dma_io_radr_en & (dma_io_radr == ADR_DATA);

   // Only the low 16 write-data bits map onto register fields.
   logic unused_wdata;
   assign unused_wdata = ^dma_io_wdata[31:16];

   // ------------------------------------------------------------------
   // CTRL register
   // ------------------------------------------------------------------
   logic       en_q, irq_en_q;
   logic [7:0] dflt_q;
   logic       flush;

   assign flush = wr_ctrl & ~dma_io_wdata[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         dflt_q   <= 8'h00;
      end else if (wr_ctrl) begin
         en_q     <= dma_io_wdata[0];
         irq_en_q <= dma_io_wdata[1];
         dflt_q   <= dma_io_wdata[15:8];
      end
   end

   // ------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------
   logic [7:0]    tx_mem_q [DEPTH];
   logic [7:0]    rx_mem_q [DEPTH];
   logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   logic [CW-1:0] tx_cnt_q, rx_cnt_q;

   logic tx_full, tx_empty, rx_full, rx_empty;
   assign tx_full  = (tx_cnt_q == CNT_FULL);
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CNT_FULL);
   assign rx_empty = (rx_cnt_q == '0);

   // FSM-side strobes, used both by the FSM and by the FIFOs
   state_t     state_q;
   logic [7:0] shift_tx_q, shift_rx_q;
   logic [2:0] bitcnt_q;
   logic       reload_q;
   logic       abort, in_shift, load_now, rx_done;
   logic [7:0] tx_next_byte, rx_byte;

   // A CSN rising edge or enable=0 drops any transfer in progress.
   assign abort        = csn_rise | ~en_q;
   assign in_shift     = (state_q == ST_SHIFT);
   assign load_now     = ~abort & ((state_q == ST_LOAD) |
                                   (in_shift & sck_fall & reload_q));
   assign tx_next_byte = tx_empty ? dflt_q : tx_mem_q[tx_rp_q];
   assign rx_byte      = {shift_rx_q[6:0], mosi_s};
   assign rx_done      = ~abort & in_shift & sck_rise & (bitcnt_q == 3'd7);

   logic tx_push, tx_pop, rx_push, rx_pop;
   assign tx_push = wr_data & ~tx_full;
   assign tx_pop  = load_now & ~tx_empty;
   assign rx_push = rx_done & ~rx_full;
   assign rx_pop  = rd_data & ~rx_empty;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= dma_io_wdata[7:0];
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else if (flush) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + PTR_ONE;
         if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_ONE;
         if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CNT_ONE;
         else if (tx_pop && !tx_push) tx_cnt_q <= tx_cnt_q - CNT_ONE;

         if (rx_push) rx_wp_q <= rx_wp_q + PTR_ONE;
         if (rx_pop)  rx_rp_q <= rx_rp_q + PTR_ONE;
         if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CNT_ONE;
         else if (rx_pop && !rx_push) rx_cnt_q <= rx_cnt_q - CNT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Sticky status flags. A new event in the same cycle as a W1C wins,
   // so no event is ever lost.
   // ------------------------------------------------------------------
   logic rx_ovf_q, tx_ovf_q, tx_unr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ovf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
         tx_unr_q <= 1'b0;
      end else begin
         if (rx_done && rx_full)                rx_ovf_q <= 1'b1;
         else if (wr_stat && dma_io_wdata[3])   rx_ovf_q <= 1'b0;

         if (wr_data && tx_full)                tx_ovf_q <= 1'b1;
         else if (wr_stat && dma_io_wdata[2])   tx_ovf_q <= 1'b0;

         if (load_now && tx_empty)              tx_unr_q <= 1'b1;
         else if (wr_stat && dma_io_wdata[1])   tx_unr_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Transfer FSM: IDLE -> LOAD -> SHIFT -> IDLE
   // ------------------------------------------------------------------
   logic miso_q, oe_q, irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shift_tx_q <= 8'h00;
         shift_rx_q <= 8'h00;
         bitcnt_q   <= 3'd0;
         reload_q   <= 1'b0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         irq_q <= rx_done & irq_en_q;
         case (state_q)
            ST_IDLE: begin
               miso_q   <= 1'b0;
               oe_q     <= 1'b0;
               reload_q <= 1'b0;
               if (en_q && csn_fall) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  miso_q  <= 1'b0;
                  oe_q    <= 1'b0;
               end else begin
                  shift_tx_q <= tx_next_byte;
                  miso_q     <= tx_next_byte[7];
                  oe_q       <= 1'b1;
                  bitcnt_q   <= 3'd0;
                  reload_q   <= 1'b0;
                  state_q    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  state_q  <= ST_IDLE;
                  miso_q   <= 1'b0;
                  oe_q     <= 1'b0;
                  reload_q <= 1'b0;
               end else begin
                  if (sck_rise) begin
                     shift_rx_q <= rx_byte;
                     bitcnt_q   <= bitcnt_q + 3'd1;
                     // A completed byte means the next falling edge starts
                     // the next TX byte instead of shifting.
                     if (bitcnt_q == 3'd7) reload_q <= 1'b1;
                  end
                  if (sck_fall) begin
                     if (reload_q) begin
                        shift_tx_q <= tx_next_byte;
                        miso_q     <= tx_next_byte[7];
                        reload_q   <= 1'b0;
                     end else begin
                        shift_tx_q <= {shift_tx_q[6:0], 1'b0};
                        miso_q     <= shift_tx_q[6];
                     end
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               miso_q  <= 1'b0;
               oe_q    <= 1'b0;
            end
         endcase
      end
   end

   assign spi_miso_out = miso_q;
   assign spi_miso_oe  = oe_q;
   assign spi_rx_1shot = irq_q;

   // ------------------------------------------------------------------
   // Read mux and daisy chain. STATUS count fields are 3 bits wide.
   // ------------------------------------------------------------------
   logic [2:0] rx_cnt3, tx_cnt3;
   assign rx_cnt3 = 3'(rx_cnt_q);
   assign tx_cnt3 = 3'(tx_cnt_q);

   always_comb begin
      dma_io_rdata = dma_io_rdata_in;
      if (dma_io_radr_en) begin
         if (dma_io_radr == ADR_DATA)
            dma_io_rdata = {23'd0, ~rx_empty, rx_mem_q[rx_rp_q]};
         else if (dma_io_radr == ADR_STAT)
            dma_io_rdata = {19'd0, rx_cnt3, tx_cnt3, 3'd0,
                            rx_ovf_q, tx_ovf_q, tx_unr_q, cs_active};
         else if (dma_io_radr == ADR_CTRL)
            dma_io_rdata = {16'd0, dflt_q, 6'd0, irq_en_q, en_q};
      end
   end

endmodule

// File: tb/tb_io_spi_target.sv
module tb_io_spi_target;

   localparam logic [13:0] ADR_DATA = 14'h3F20;
   localparam logic [13:0] ADR_STAT = 14'h3F21;
   localparam logic [13:0] ADR_CTRL = 14'h3F22;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dma_io_we = 1'b0;
   logic [15:2] dma_io_wadr = '0;
   logic [31:0] dma_io_wdata = '0;
   logic [15:2] dma_io_radr = '0;
   logic        dma_io_radr_en = 1'b0;
   logic [31:0] dma_io_rdata_in = '0;
   logic [31:0] dma_io_rdata;
   logic        spi_sck_in = 1'b0;
   logic        spi_csn_in = 1'b1;
   logic        spi_mosi_in = 1'b0;
   logic        spi_miso_out;
   logic        spi_miso_oe;
   logic        spi_rx_1shot;

   int n_checks = 0;
   int n_errors = 0;
   int irq_cnt  = 0;

   io_spi_target dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dma_io_we       (dma_io_we),
      .dma_io_wadr     (dma_io_wadr),
      .dma_io_wdata    (dma_io_wdata),
      .dma_io_radr     (dma_io_radr),
      .dma_io_radr_en  (dma_io_radr_en),
      .dma_io_rdata_in (dma_io_rdata_in),
      .dma_io_rdata    (dma_io_rdata),
      .spi_sck_in      (spi_sck_in),
      .spi_csn_in      (spi_csn_in),
      .spi_mosi_in     (spi_mosi_in),
      .spi_miso_out    (spi_miso_out),
      .spi_miso_oe     (spi_miso_oe),
      .spi_rx_1shot    (spi_rx_1shot)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (spi_rx_1shot) irq_cnt <= irq_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      dma_io_we    = 1'b1;
      dma_io_wadr  = a;
      dma_io_wdata = d;
      @(negedge clk);
      dma_io_we    = 1'b0;
   endtask

   task automatic bus_rd(input logic [13:0] a, output logic [31:0] d);
      @(negedge clk);
      dma_io_radr    = a;
      dma_io_radr_en = 1'b1;
      #1 d = dma_io_rdata;
      @(negedge clk);
      dma_io_radr_en = 1'b0;
   endtask

   task automatic frame_begin();
      spi_csn_in = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic frame_end();
      repeat (5) @(negedge clk);
      spi_csn_in = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // One byte, SCK = clk/10. MISO is sampled at the end of each low phase.
   task automatic spi_byte(input logic [7:0] mo, input logic [7:0] exp_mi,
                           input bit chk);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi_in = mo[i];
         repeat (5) @(negedge clk);
         if (chk) begin
            check_eq($sformatf("miso_b%0d", i), {31'd0, spi_miso_out},
                     {31'd0, exp_mi[i]});
            check_eq("miso_oe", {31'd0, spi_miso_oe}, 32'd1);
         end
         spi_sck_in = 1'b1;
         repeat (5) @(negedge clk);
         spi_sck_in = 1'b0;
      end
   endtask

   logic [31:0] rd;
   int          irq0;

   initial begin
      // 1. reset state and pass-through
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_miso", {31'd0, spi_miso_out}, 32'd0);
      check_eq("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
      check_eq("rst_irq", {31'd0, spi_rx_1shot}, 32'd0);
      dma_io_rdata_in = 32'hdeadbeef;
      #1 check_eq("rst_chain_idle", dma_io_rdata, 32'hdeadbeef);
      bus_rd(ADR_STAT, rd);
      check_eq("rst_status", rd, 32'h0);
      bus_rd(ADR_CTRL, rd);
      check_eq("rst_ctrl", rd, 32'h0);
      bus_rd(14'h0010, rd);
      check_eq("chain_other", rd, 32'hdeadbeef);

      // 2. basic byte exchange
      bus_wr(ADR_CTRL, 32'h0000_0001);
      bus_wr(ADR_DATA, 32'h0000_00A5);
      frame_begin();
      spi_byte(8'h3C, 8'hA5, 1'b1);
      frame_end();
      check_eq("oe_after_frame", {31'd0, spi_miso_oe}, 32'd0);
      bus_rd(ADR_STAT, rd);
      check_eq("t2_rxcnt1", (rd >> 10) & 32'h7, 32'd1);
      bus_rd(ADR_DATA, rd);
      check_eq("t2_data", rd, 32'h13C);
      bus_rd(ADR_STAT, rd);
      check_eq("t2_rxcnt0", (rd >> 10) & 32'h7, 32'd0);

      // 3. underrun with default byte and receive interrupt
      bus_wr(ADR_STAT, 32'hE);
      bus_wr(ADR_CTRL, 32'h0000_FF03);
      bus_rd(ADR_STAT, rd);
      check_eq("t3_cleared", rd & 32'hE, 32'h0);
      irq0 = irq_cnt;
      frame_begin();
      spi_byte(8'h12, 8'hFF, 1'b1);
      spi_byte(8'h34, 8'hFF, 1'b1);
      frame_end();
      check_eq("t3_irq_count", 32'(irq_cnt - irq0), 32'd2);
      bus_rd(ADR_STAT, rd);
      check_eq("t3_underrun", rd & 32'h2, 32'h2);
      bus_wr(ADR_STAT, 32'h2);
      bus_rd(ADR_STAT, rd);
      check_eq("t3_w1c", rd & 32'h2, 32'h0);
      bus_rd(ADR_DATA, rd);
      check_eq("t3_rx0", rd, 32'h112);
      bus_rd(ADR_DATA, rd);
      check_eq("t3_rx1", rd, 32'h134);

      // 4. RX overflow
      frame_begin();
      for (int b = 1; b <= 5; b++) spi_byte(8'(b), 8'hFF, 1'b0);
      frame_end();
      bus_rd(ADR_STAT, rd);
      check_eq("t4_rxcnt4", (rd >> 10) & 32'h7, 32'd4);
      check_eq("t4_rx_ovf", rd & 32'h8, 32'h8);
      for (int b = 1; b <= 4; b++) begin
         bus_rd(ADR_DATA, rd);
         check_eq($sformatf("t4_rx%0d", b), rd, 32'h100 | 32'(b));
      end
      bus_rd(ADR_DATA, rd);
      check_eq("t4_empty_valid", rd & 32'h100, 32'h0);
      bus_wr(ADR_STAT, 32'h8);

      // 5. aborted frame, then a clean one
      frame_begin();
      spi_mosi_in = 1'b1;
      repeat (5) @(negedge clk);
      spi_sck_in = 1'b1;
      repeat (5) @(negedge clk);
      spi_sck_in = 1'b0;
      repeat (5) @(negedge clk);
      spi_sck_in = 1'b1;
      repeat (5) @(negedge clk);
      spi_csn_in = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("t5_oe_off", {31'd0, spi_miso_oe}, 32'd0);
      spi_sck_in = 1'b0;
      repeat (10) @(negedge clk);
      bus_rd(ADR_STAT, rd);
      check_eq("t5_no_push", (rd >> 10) & 32'h7, 32'd0);
      frame_begin();
      spi_byte(8'h5A, 8'hFF, 1'b1);
      frame_end();
      bus_rd(ADR_DATA, rd);
      check_eq("t5_rx", rd, 32'h15A);

      // 6. TX overflow and flush
      for (int b = 0; b < 5; b++) bus_wr(ADR_DATA, 32'h40 + 32'(b));
      bus_rd(ADR_STAT, rd);
      check_eq("t6_txcnt4", (rd >> 7) & 32'h7, 32'd4);
      check_eq("t6_tx_ovf", rd & 32'h4, 32'h4);
      bus_wr(ADR_CTRL, 32'h0);
      bus_rd(ADR_STAT, rd);
      check_eq("t6_flushed", (rd >> 7) & 32'h7, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
